// File: rtl/csr_file_pkg.sv
// Shared CSR operation types and the CSR address map for the writeback-stage CSR unit.
package csr_file_pkg;

  typedef enum logic [1:0] {
    CSR_WRITE_NONE = 2'd0,
    CSR_WRITE_RW   = 2'd1,
    CSR_WRITE_RS   = 2'd2,
    CSR_WRITE_RC   = 2'd3
  } csr_write_func;

  typedef enum logic {
    CSR_INPUT_RS1 = 1'b0,
    CSR_INPUT_IMM = 1'b1
  } csr_input_sel;

  typedef struct packed {
    logic          read_enable;
    logic          write_enable;
    csr_write_func write_func;
    csr_input_sel  input_select;
    logic [4:0]    imm_value;
  } csr_params;

  localparam logic [11:0] CSR_MSCRATCH     = 12'h340;
  localparam logic [11:0] CSR_SCRATCH_BASE = 12'h7C0;
  localparam logic [11:0] CSR_MCYCLE       = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH      = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET     = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH    = 12'hB82;
  localparam logic [11:0] CSR_CYCLE        = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH       = 12'hC80;
  localparam logic [11:0] CSR_INSTRET      = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH     = 12'hC82;

  // The top two address bits encode the read-only CSR space.
  function automatic logic csr_is_read_only(input logic [11:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/csr_file_counter.sv
// Free-running counter wider than XLEN, readable and writable one XLEN half at a time.
module csr_file_counter #(
  parameter int COUNTER_WIDTH = 64,
  parameter int XLEN          = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc_en,
  input  logic            wr_en,
  input  logic            wr_hi,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] rd_lo,
  output logic [XLEN-1:0] rd_hi
);

  localparam int HI_W = COUNTER_WIDTH - XLEN;

  logic [COUNTER_WIDTH-1:0] count;

  // A write replaces this cycle's increment; the unwritten half keeps its pre-increment value.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (wr_en) begin
      if (wr_hi) begin
        count <= {wr_data[HI_W-1:0], count[XLEN-1:0]};
      end else begin
        count <= {count[COUNTER_WIDTH-1:XLEN], wr_data};
      end
    end else if (inc_en) begin
      count <= count + COUNTER_WIDTH'(1);
    end
  end

  assign rd_lo = count[XLEN-1:0];
  assign rd_hi = XLEN'(count[COUNTER_WIDTH-1:XLEN]);

endmodule

// File: rtl/csr_file.sv
// CSR storage and atomic read-modify-write unit with a one-entry response buffer,
// mcycle/minstret counters and a bank of custom scratch CSRs.
module csr_file
  import csr_file_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int NUM_SCRATCH   = 4,
  parameter int COUNTER_WIDTH = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  csr_params       req_params,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_rs1,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_illegal,
  input  logic            retire
);

  localparam int IDX_W = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;

  logic            accept;
  logic            mapped;
  logic            scratch_hit;
  logic [IDX_W-1:0] scratch_idx;
  logic            illegal;
  logic            do_write;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] src_val;
  logic [XLEN-1:0] new_val;
  logic [XLEN-1:0] rdata_next;

  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] scratch [NUM_SCRATCH];

  logic [XLEN-1:0] mcycle_lo, mcycle_hi;
  logic [XLEN-1:0] minstret_lo, minstret_hi;
  logic            mcycle_wr, minstret_wr;

  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;

  assign scratch_hit = (req_addr[11:5] == CSR_SCRATCH_BASE[11:5]) &&
                       ({1'b0, req_addr[4:0]} < 6'(NUM_SCRATCH));
  assign scratch_idx = req_addr[IDX_W-1:0];

  // Address decode and old-value mux; counter aliases share the same storage.
  always_comb begin
    mapped  = 1'b1;
    old_val = '0;
    case (req_addr)
      CSR_MSCRATCH:              old_val = mscratch;
      CSR_MCYCLE, CSR_CYCLE:     old_val = mcycle_lo;
      CSR_MCYCLEH, CSR_CYCLEH:   old_val = mcycle_hi;
      CSR_MINSTRET, CSR_INSTRET: old_val = minstret_lo;
      CSR_MINSTRETH, CSR_INSTRETH: old_val = minstret_hi;
      default: begin
        if (scratch_hit) begin
          old_val = scratch[scratch_idx];
        end else begin
          mapped = 1'b0;
        end
      end
    endcase
  end

  assign illegal = !mapped ||
                   (req_params.write_enable && csr_is_read_only(req_addr));

  assign src_val = (req_params.input_select == CSR_INPUT_IMM) ?
                   XLEN'(req_params.imm_value) : req_rs1;

  always_comb begin
    new_val = old_val;
    case (req_params.write_func)
      CSR_WRITE_RW: new_val = src_val;
      CSR_WRITE_RS: new_val = old_val | src_val;
      CSR_WRITE_RC: new_val = old_val & ~src_val;
      default:      new_val = old_val;
    endcase
  end

  assign do_write = accept && !illegal && req_params.write_enable &&
                    (req_params.write_func != CSR_WRITE_NONE);

  assign rdata_next = (req_params.read_enable && !illegal) ? old_val : '0;

  assign mcycle_wr   = do_write && ((req_addr == CSR_MCYCLE) || (req_addr == CSR_MCYCLEH));
  assign minstret_wr = do_write && ((req_addr == CSR_MINSTRET) || (req_addr == CSR_MINSTRETH));

  csr_file_counter #(
    .COUNTER_WIDTH(COUNTER_WIDTH),
    .XLEN         (XLEN)
  ) u_mcycle (
    .clk    (clk),
    .reset  (reset),
    .inc_en (1'b1),
    .wr_en  (mcycle_wr),
    .wr_hi  (req_addr == CSR_MCYCLEH),
    .wr_data(new_val),
    .rd_lo  (mcycle_lo),
    .rd_hi  (mcycle_hi)
  );

  csr_file_counter #(
    .COUNTER_WIDTH(COUNTER_WIDTH),
    .XLEN         (XLEN)
  ) u_minstret (
    .clk    (clk),
    .reset  (reset),
    .inc_en (retire),
    .wr_en  (minstret_wr),
    .wr_hi  (req_addr == CSR_MINSTRETH),
    .wr_data(new_val),
    .rd_lo  (minstret_lo),
    .rd_hi  (minstret_hi)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mscratch <= '0;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch[i] <= '0;
      end
    end else if (do_write) begin
      if (req_addr == CSR_MSCRATCH) begin
        mscratch <= new_val;
      end
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (scratch_hit && (scratch_idx == IDX_W'(i))) begin
          scratch[i] <= new_val;
        end
      end
    end
  end

  // A new accept overwrites the buffer even if the old response is popped in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_illegal <= 1'b0;
    end else if (accept) begin
      resp_valid   <= 1'b1;
      resp_rdata   <= rdata_next;
      resp_illegal <= illegal;
    end else if (resp_ready) begin
      resp_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Directed scoreboard bench for csr_file: expectations are queued on accept and checked on pop.
module tb_csr_file;
  import csr_file_pkg::*;

  localparam int XLEN          = 32;
  localparam int NUM_SCRATCH   = 4;
  localparam int COUNTER_WIDTH = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  csr_params       req_params;
  logic [11:0]     req_addr = '0;
  logic [XLEN-1:0] req_rs1 = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b1;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_illegal;
  logic            retire = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string           tag;
    logic [XLEN-1:0] rdata;
    logic            illegal;
  } exp_t;

  exp_t sb[$];

  csr_file #(
    .XLEN         (XLEN),
    .NUM_SCRATCH  (NUM_SCRATCH),
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_params  (req_params),
    .req_addr    (req_addr),
    .req_rs1     (req_rs1),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_illegal(resp_illegal),
    .retire      (retire)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] obs,
                             input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input string tag, input logic [XLEN-1:0] rdata, input logic ill);
    exp_t e;
    e.tag     = tag;
    e.rdata   = rdata;
    e.illegal = ill;
    sb.push_back(e);
  endtask

  task automatic driveReq(input logic re, input logic we, input csr_write_func f,
                          input csr_input_sel sel, input logic [4:0] imm,
                          input logic [11:0] addr, input logic [XLEN-1:0] rs1);
    req_valid               = 1'b1;
    req_params.read_enable  = re;
    req_params.write_enable = we;
    req_params.write_func   = f;
    req_params.input_select = sel;
    req_params.imm_value    = imm;
    req_addr                = addr;
    req_rs1                 = rs1;
  endtask

  // One request, held for exactly one cycle; expectation queued only if it was accepted.
  task automatic applyStimulus(input string tag, input logic re, input logic we,
                               input csr_write_func f, input csr_input_sel sel,
                               input logic [4:0] imm, input logic [11:0] addr,
                               input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] exp_rdata,
                               input logic exp_ill);
    driveReq(re, we, f, sel, imm, addr, rs1);
    @(negedge clk);
    checkOutput({tag, "_ready"}, XLEN'(req_ready), 32'd1);
    if (req_ready === 1'b1) pushExp(tag, exp_rdata, exp_ill);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && resp_valid === 1'b1 && resp_ready === 1'b1) begin : pop_blk
      exp_t e;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_resp observed=%h expected=none", resp_rdata);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput({e.tag, "_rdata"}, resp_rdata, e.rdata);
        checkOutput({e.tag, "_illegal"}, XLEN'(resp_illegal), XLEN'(e.illegal));
      end
    end
  end

  initial begin
    int guard;
    req_params = '0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_resp_valid", XLEN'(resp_valid), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_resp_illegal", XLEN'(resp_illegal), 32'd0);
    checkOutput("rst_req_ready", XLEN'(req_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;

    applyStimulus("mcycle_5", 1, 0, CSR_WRITE_NONE, CSR_INPUT_RS1, 0, CSR_MCYCLE, 0, 32'd5, 0);
    applyStimulus("mcycleh_0", 1, 0, CSR_WRITE_NONE, CSR_INPUT_RS1, 0, CSR_MCYCLEH, 0, 32'd0, 0);

    applyStimulus("ms_rw", 1, 1, CSR_WRITE_RW, CSR_INPUT_RS1, 0, CSR_MSCRATCH, 32'hDEADBEEF, 32'd0, 0);
    applyStimulus("ms_rs", 1, 1, CSR_WRITE_RS, CSR_INPUT_IMM, 5'd3, CSR_MSCRATCH, 0, 32'hDEADBEEF, 0);
    applyStimulus("ms_rd", 1, 0, CSR_WRITE_NONE, CSR_INPUT_RS1, 0, CSR_MSCRATCH, 0, 32'hDEADBEEF, 0);
    applyStimulus("ms_rc", 1, 1, CSR_WRITE_RC, CSR_INPUT_IMM, 5'hF, CSR_MSCRATCH, 0, 32'hDEADBEEF, 0);
    applyStimulus("ms_rd2", 1, 0, CSR_WRITE_NONE, CSR_INPUT_RS1, 0, CSR_MSCRATCH, 0, 32'hDEADBEE0, 0);
    applyStimulus("noop", 0, 0, CSR_WRITE_NONE, CSR_INPUT_RS1, 0, CSR_MSCRATCH, 32'hFFFF, 32'd0, 0);

    applyStimulus("sc3_rw", 1, 1, CSR_WRITE_RW, CSR_INPUT_RS1, 0, 12'h7C3, 32'hFF, 32'd0, 0);
    applyStimulus("sc3_rc", 1, 1, CSR_WRITE_RC, CSR_INPUT_RS1, 0, 12'h7C3, 32'hF0, 32'hFF, 0);
    applyStimulus("sc0_rw", 0, 1, CSR_WRITE_RW, CSR_INPUT_RS1, 0, 12'h7C0, 32'hA5, 32'd0, 0);
    applyStimulus("sc3_rd", 1, 0, CSR_WRITE_NONE, CSR_INPUT_RS1, 0, 12'h7C3, 0, 32'h0F, 0);
    applyStimulus("sc0_rd", 1, 0, CSR_WRITE_NONE, CSR_INPUT_RS1, 0, 12'h7C0, 0, 32'hA5, 0);
    applyStimulus("sc_oob", 1, 0, CSR_WRITE_NONE, CSR_INPUT_RS1, 0, 12'h7C4, 0, 32'd0, 1);
    applyStimulus("unmapped", 1, 1, CSR_WRITE_RW, CSR_INPUT_RS1, 0, 12'h341, 32'h1, 32'd0, 1);

    applyStimulus("mcyc_wr", 0, 1, CSR_WRITE_RW, CSR_INPUT_RS1, 0, CSR_MCYCLE, 32'hFFFFFFFF, 32'd0, 0);
    @(posedge clk);
    #1;
    applyStimulus("mcych_wrap", 1, 0, CSR_WRITE_NONE, CSR_INPUT_RS1, 0, CSR_MCYCLEH, 0, 32'd1, 0);
    applyStimulus("mcyc_lo_wrap", 1, 0, CSR_WRITE_NONE, CSR_INPUT_RS1, 0, CSR_MCYCLE, 0, 32'd1, 0);

    retire = 1'b1;
    applyStimulus("minst_wr", 0, 1, CSR_WRITE_RW, CSR_INPUT_RS1, 0, CSR_MINSTRET, 32'h12345678, 32'd0, 0);
    retire = 1'b0;
    applyStimulus("minst_rd", 1, 0, CSR_WRITE_NONE, CSR_INPUT_RS1, 0, CSR_MINSTRET, 0, 32'h12345678, 0);
    retire = 1'b1;
    repeat (3) @(posedge clk);
    #1 retire = 1'b0;
    applyStimulus("inst_alias", 1, 0, CSR_WRITE_NONE, CSR_INPUT_RS1, 0, CSR_INSTRET, 0, 32'h1234567B, 0);
    applyStimulus("inst_wr_ill", 1, 1, CSR_WRITE_RW, CSR_INPUT_RS1, 0, CSR_INSTRET, 0, 32'd0, 1);
    applyStimulus("minst_kept", 1, 0, CSR_WRITE_NONE, CSR_INPUT_RS1, 0, CSR_MINSTRET, 0, 32'h1234567B, 0);
    applyStimulus("cyc_wr_ill", 1, 1, CSR_WRITE_RW, CSR_INPUT_RS1, 0, CSR_CYCLE, 32'h0, 32'd0, 1);
    applyStimulus("cych_rd", 1, 0, CSR_WRITE_NONE, CSR_INPUT_RS1, 0, CSR_CYCLEH, 0, 32'd1, 0);

    // Backpressure: hold the response, then release into two back-to-back accepts.
    repeat (2) @(posedge clk);
    #1 resp_ready = 1'b0;
    applyStimulus("bp_a", 1, 0, CSR_WRITE_NONE, CSR_INPUT_RS1, 0, CSR_MSCRATCH, 0, 32'hDEADBEE0, 0);
    driveReq(1, 0, CSR_WRITE_NONE, CSR_INPUT_RS1, 0, 12'h7C3, 0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_ready_low", XLEN'(req_ready), 32'd0);
      checkOutput("bp_hold_valid", XLEN'(resp_valid), 32'd1);
      checkOutput("bp_hold_rdata", resp_rdata, 32'hDEADBEE0);
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_ready", XLEN'(req_ready), 32'd1);
    if (req_ready === 1'b1) pushExp("bp_b", 32'h0F, 0);
    @(posedge clk);
    #1;
    driveReq(1, 0, CSR_WRITE_NONE, CSR_INPUT_RS1, 0, CSR_INSTRETH, 0);
    @(negedge clk);
    checkOutput("b2b_valid_1", XLEN'(resp_valid), 32'd1);
    checkOutput("b2b_ready", XLEN'(req_ready), 32'd1);
    if (req_ready === 1'b1) pushExp("bp_c", 32'd0, 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_valid_2", XLEN'(resp_valid), 32'd1);
    @(posedge clk);
    #1;

    // Reset while a response is held, with a competing write in the same cycle.
    resp_ready = 1'b0;
    applyStimulus("held", 1, 0, CSR_WRITE_NONE, CSR_INPUT_RS1, 0, CSR_MSCRATCH, 0, 32'hDEADBEE0, 0);
    @(negedge clk);
    checkOutput("held_valid", XLEN'(resp_valid), 32'd1);
    #1;
    reset = 1'b1;
    resp_ready = 1'b1;
    driveReq(1, 1, CSR_WRITE_RW, CSR_INPUT_RS1, 0, CSR_MSCRATCH, 32'h55);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_valid", XLEN'(resp_valid), 32'd0);
    checkOutput("mid_rst_rdata", resp_rdata, 32'd0);
    checkOutput("mid_rst_illegal", XLEN'(resp_illegal), 32'd0);
    checkOutput("mid_rst_ready", XLEN'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus("ms_after_rst", 1, 0, CSR_WRITE_NONE, CSR_INPUT_RS1, 0, CSR_MSCRATCH, 0, 32'd0, 0);
    applyStimulus("mcych_after_rst", 1, 0, CSR_WRITE_NONE, CSR_INPUT_RS1, 0, CSR_MCYCLEH, 0, 32'd0, 0);

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("[TB] FAIL drain observed=%0d pending expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
